// File: rtl/risc_pkg.sv
// Shared register-file widths and the write-queue entry type used by the writeback path.
package risc_pkg;
  localparam int REG_W      = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] tgt;
    logic [REG_W-1:0]      data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    reg_onehot    = '0;
    reg_onehot[r] = 1'b1;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Writeback queue: two pushes (push0 older) and one pop per cycle; an empty queue passes the
// oldest push straight to the pop port in the same cycle. Entries are exposed oldest-first.
module wb_fifo
  import risc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push0_vld,
  input  logic [ENTRY_W-1:0]         push0_dat,
  input  logic                       push1_vld,
  input  logic [ENTRY_W-1:0]         push1_dat,
  output logic                       pop_vld,
  output logic [ENTRY_W-1:0]         pop_dat,
  output logic [CNT_W-1:0]           count,
  output logic [DEPTH-1:0]           ord_vld,
  output logic [DEPTH*ENTRY_W-1:0]   ord_dat
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       n_push, enq_n;
  logic             q_nonempty;
  wb_entry_t        first, enq0, enq1;

  always_comb begin
    q_nonempty = (count_q != '0);
    n_push     = {1'b0, push0_vld} + {1'b0, push1_vld};
    first      = push0_vld ? push0_dat : push1_dat;
    pop_vld    = q_nonempty || (n_push != 2'd0);
    pop_dat    = q_nonempty ? mem_q[rd_ptr_q] : first;
    // With an empty queue the oldest push is the pop, so only the second push is stored.
    if (q_nonempty) begin
      enq_n = n_push;
      enq0  = first;
      enq1  = push1_dat;
    end else begin
      enq_n = (n_push == 2'd2) ? 2'd1 : 2'd0;
      enq0  = push1_dat;
      enq1  = push1_dat;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(enq_n);
    rd_ptr_d = rd_ptr_q + PTR_W'(q_nonempty);
    count_d  = count_q + CNT_W'(enq_n) - CNT_W'(q_nonempty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_n != 2'd0) mem_q[wr_ptr_q] <= enq0;
    if (enq_n == 2'd2) mem_q[wr_ptr_q + PTR_W'(1)] <= enq1;
  end

  assign count = count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ord
    logic [PTR_W-1:0] idx;
    assign idx                            = rd_ptr_q + PTR_W'(i);
    assign ord_dat[i*ENTRY_W +: ENTRY_W]  = mem_q[idx];
    assign ord_vld[i]                     = (CNT_W'(i) < count_q);
  end

endmodule

// File: rtl/rf_writeback.sv
// Merges ALU and load results into a write queue draining one register write per cycle
// (1-cycle latency when idle); in_ready drops below two free slots. Forwards queued operands.
module rf_writeback
  import risc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_tgt,
  input  logic [REG_W-1:0]      alu_data,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_tgt,
  input  logic [REG_W-1:0]      mem_data,
  output logic                  in_ready,
  output logic                  we_reg,
  output logic [REG_ADDR_W-1:0] tgt,
  output logic [REG_W-1:0]      write_data,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic [REG_W-1:0]      rf_src1_val,
  input  logic [REG_W-1:0]      rf_src2_val,
  output logic [REG_W-1:0]      src1_val,
  output logic [REG_W-1:0]      src2_val,
  output logic [NUM_REGS-1:0]   pending
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]         count;
  logic                     mem_acc, alu_acc;
  wb_entry_t                mem_ent, alu_ent, pop_ent;
  logic                     pop_vld;
  logic [DEPTH-1:0]         ord_vld;
  logic [DEPTH*ENTRY_W-1:0] ord_dat;

  logic                     we_q, we_d;
  logic [REG_ADDR_W-1:0]    tgt_q, tgt_d;
  logic [REG_W-1:0]         wdata_q, wdata_d;

  assign in_ready = ((CNT_W'(DEPTH) - count) >= CNT_W'(2));
  // Writes to r0 are architecturally void, so they never occupy a slot.
  assign mem_acc  = mem_valid && in_ready && (mem_tgt != '0);
  assign alu_acc  = alu_valid && in_ready && (alu_tgt != '0);
  assign mem_ent  = '{tgt: mem_tgt, data: mem_data};
  assign alu_ent  = '{tgt: alu_tgt, data: alu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push0_vld (mem_acc),
    .push0_dat (mem_ent),
    .push1_vld (alu_acc),
    .push1_dat (alu_ent),
    .pop_vld   (pop_vld),
    .pop_dat   (pop_ent),
    .count     (count),
    .ord_vld   (ord_vld),
    .ord_dat   (ord_dat)
  );

  always_comb begin
    we_d    = pop_vld;
    tgt_d   = pop_vld ? pop_ent.tgt  : tgt_q;
    wdata_d = pop_vld ? pop_ent.data : wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      tgt_q   <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      tgt_q   <= tgt_d;
      wdata_q <= wdata_d;
    end
  end

  assign we_reg     = we_q;
  assign tgt        = tgt_q;
  assign write_data = wdata_q;

  // Priority rises with age order: write port, then queue oldest to youngest.
  function automatic logic [REG_W-1:0] fwd_val(
    input logic [REG_ADDR_W-1:0]    src,
    input logic [REG_W-1:0]         rf_val,
    input logic [DEPTH-1:0]         vld,
    input logic [DEPTH*ENTRY_W-1:0] dat,
    input logic                     wp_we,
    input logic [REG_ADDR_W-1:0]    wp_tgt,
    input logic [REG_W-1:0]         wp_data
  );
    wb_entry_t e;
    fwd_val = rf_val;
    if (wp_we && (wp_tgt == src)) fwd_val = wp_data;
    for (int i = 0; i < DEPTH; i++) begin
      e = dat[i*ENTRY_W +: ENTRY_W];
      if (vld[i] && (e.tgt == src)) fwd_val = e.data;
    end
    if (src == '0) fwd_val = '0;
  endfunction

  assign src1_val = fwd_val(src1, rf_src1_val, ord_vld, ord_dat, we_q, tgt_q, wdata_q);
  assign src2_val = fwd_val(src2, rf_src2_val, ord_vld, ord_dat, we_q, tgt_q, wdata_q);

  wb_entry_t           pend_e;
  logic [NUM_REGS-1:0] pend;

  always_comb begin
    pend   = '0;
    pend_e = '0;
    if (we_q) pend = pend | reg_onehot(tgt_q);
    for (int i = 0; i < DEPTH; i++) begin
      pend_e = ord_dat[i*ENTRY_W +: ENTRY_W];
      if (ord_vld[i]) pend = pend | reg_onehot(pend_e.tgt);
    end
    pend[0] = 1'b0;
  end

  assign pending = pend;

  // Upstream must stall while in_ready is low; a valid here would be silently dropped.
  a_no_drop: assert property (@(posedge clk) disable iff (!rst_n)
                              (alu_valid || mem_valid) |-> in_ready);

endmodule
